// File: rtl/nco_sweep_ctrl_if.sv
// Request/status bundle between a sweep host and the nco sweep controller.
// The master drives the sweep programme; the slave returns the phase increment and status flags.
interface nco_sweep_ctrl_if #(
  parameter int PHI_W   = 16,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic               mode;
  logic [PHI_W-1:0]   f_start;
  logic [PHI_W-1:0]   f_stop;
  logic [PHI_W-1:0]   f_step;
  logic [DWELL_W-1:0] dwell;
  logic [PHI_W-1:0]   phi_inc_o;
  logic               busy;
  logic               step_strobe;
  logic               sweep_done;

  modport master (
    output start, abort, mode, f_start, f_stop, f_step, dwell,
    input  phi_inc_o, busy, step_strobe, sweep_done
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_step, dwell,
    output phi_inc_o, busy, step_strobe, sweep_done
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep generator feeding the nco phase increment.
// Holds each increment dwell+1 enabled cycles, steps toward f_stop with clamping, single or continuous.
module nco_sweep_ctrl #(
  parameter int PHI_W   = 16,
  parameter int DWELL_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  nco_sweep_ctrl_if.slave  sw
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PHI_W-1:0]   phi_q, phi_d;
  logic [PHI_W-1:0]   start_q, start_d;
  logic [PHI_W-1:0]   stop_q, stop_d;
  logic [PHI_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               dn_q, dn_d;
  logic               busy_q, busy_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;

  logic [PHI_W:0]     sum;
  logic [PHI_W:0]     diff;
  logic [PHI_W-1:0]   step_val;

  // One extra bit on sum/difference so a step past either end of the range clamps instead of wrapping.
  always_comb begin
    sum      = {1'b0, phi_q} + {1'b0, step_q};
    diff     = {1'b0, phi_q} - {1'b0, step_q};
    step_val = phi_q;
    if (dn_q) begin
      if (diff[PHI_W] || (diff[PHI_W-1:0] <= stop_q)) step_val = stop_q;
      else                                            step_val = diff[PHI_W-1:0];
    end else begin
      if (sum >= {1'b0, stop_q}) step_val = stop_q;
      else                       step_val = sum[PHI_W-1:0];
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case can infer a latch.
    state_d  = state_q;
    phi_d    = phi_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    dn_d     = dn_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sw.start && !sw.abort) begin
          start_d  = sw.f_start;
          stop_d   = sw.f_stop;
          step_d   = sw.f_step;
          dwell_d  = sw.dwell;
          mode_d   = sw.mode;
          dn_d     = (sw.f_stop < sw.f_start);
          phi_d    = sw.f_start;
          cnt_d    = sw.dwell;
          busy_d   = 1'b1;
          strobe_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if ((phi_q != stop_q) && (step_q != '0)) begin
          phi_d    = step_val;
          cnt_d    = dwell_q;
          strobe_d = 1'b1;
        end else if (mode_q) begin
          phi_d    = start_q;
          cnt_d    = dwell_q;
          strobe_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything; phi_inc_o keeps its last value so the nco keeps running there.
    if (sw.abort) begin
      state_d  = S_IDLE;
      phi_d    = phi_q;
      cnt_d    = cnt_q;
      busy_d   = 1'b0;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the shadow registers are few and must read zero after reset, so they are reset like the rest.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      phi_q    <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      dn_q     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (clken) begin
      state_q  <= state_d;
      phi_q    <= phi_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      dn_q     <= dn_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign sw.phi_inc_o   = phi_q;
  assign sw.busy        = busy_q;
  assign sw.step_strobe = strobe_q;
  assign sw.sweep_done  = done_q;

endmodule
